// File: rtl/generic_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : generic_bus_mem_responder
// Description : Word-RAM target for the generic bus with programmable wait
//               states, out-of-range error reporting and request abort.
// Revision    : 1.0 - initial release
// ============================================================================
module generic_bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] ERR_DATA  = 32'hBAD1_BAD1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);
    localparam int          c_idx_w = $clog2(DEPTH);
    localparam logic [3:0]  c_lat   = LATENCY[3:0];
    localparam logic [32:0] c_span  = 33'(DEPTH) << 2;

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_wait = 2'd1;
    localparam logic [1:0]  c_st_resp = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_write;
    logic               r_oor;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic [31:0]        w_sel_addr;
    logic               w_sel_write;
    logic [32:0]        w_offset;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    logic               w_enter_resp;

    // In IDLE the live request is used so a zero-latency access can be
    // served on the acceptance edge; afterwards only the latched copy counts.
    always_comb begin
        w_req        = ren | wen;
        w_sel_addr   = (r_state == c_st_idle) ? addr : r_addr;
        w_sel_write  = (r_state == c_st_idle) ? wen : r_write;
        w_offset     = {1'b0, w_sel_addr} - {1'b0, BASE_ADDR};
        w_in_range   = (w_offset < c_span);
        w_idx        = w_offset[c_idx_w+1:2];
        w_enter_resp = w_req &&
                       (((r_state == c_st_idle) && (c_lat == 4'd0)) ||
                        ((r_state == c_st_wait) && (r_cnt == 4'd1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_be    <= byte_en;
                        r_write <= wen;
                        r_cnt   <= c_lat;
                        r_state <= (c_lat == 4'd0) ? c_st_resp : c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (!w_req) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= c_st_resp;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_resp: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase

            // Read data is captured on the edge entering RESP so it is
            // already valid while busy is low.
            if (w_enter_resp) begin
                r_oor <= !w_in_range;
                if (w_sel_write) begin
                    r_rdata <= '0;
                end else if (!w_in_range) begin
                    r_rdata <= ERR_DATA;
                end else begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Commit at the end of RESP; an asynchronous reset during RESP has
    // already moved the state to IDLE, so the write is dropped.
    always_ff @(posedge clk) begin
        if ((r_state == c_st_resp) && r_write && !r_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign busy  = (r_state != c_st_resp);
    assign err   = (r_state == c_st_resp) && r_oor;

endmodule
`default_nettype wire

// File: tb/tb_generic_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_generic_bus_mem_responder
// Description : Self-checking bench for generic_bus_mem_responder at
//               latencies 2, 3 and 0 against a behavioural memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_bus_mem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ERRD = 32'hBAD1_BAD1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        ren   [3];
    logic        wen   [3];
    logic [3:0]  be    [3];
    logic [31:0] rdata [3];
    logic        busy  [3];
    logic        err   [3];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] ref_mem [3][4096];

    always #5 clk = ~clk;

    generic_bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH(4096), .LATENCY(2), .ERR_DATA(ERRD)) u_l2 (
        .clk(clk), .rst(rst), .addr(addr[0]), .wdata(wdata[0]), .ren(ren[0]), .wen(wen[0]),
        .byte_en(be[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0]));
    generic_bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .LATENCY(3), .ERR_DATA(ERRD)) u_l3 (
        .clk(clk), .rst(rst), .addr(addr[1]), .wdata(wdata[1]), .ren(ren[1]), .wen(wen[1]),
        .byte_en(be[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1]));
    generic_bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .LATENCY(0), .ERR_DATA(ERRD)) u_l0 (
        .clk(clk), .rst(rst), .addr(addr[2]), .wdata(wdata[2]), .ren(ren[2]), .wen(wen[2]),
        .byte_en(be[2]), .rdata(rdata[2]), .busy(busy[2]), .err(err[2]));

    function automatic int dep(input int u);
        return (u == 0) ? 4096 : 64;
    endfunction

    function automatic int lat(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 3 : 0);
    endfunction

    function automatic longint offs(input logic [31:0] a);
        return longint'({32'd0, a}) - longint'({32'd0, BASE});
    endfunction

    function automatic bit in_rng(input int u, input logic [31:0] a);
        return (offs(a) >= 0) && (offs(a) < 4 * longint'(dep(u)));
    endfunction

    function automatic void model_write(input int u, input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] b);
        int i;
        if (in_rng(u, a)) begin
            i = int'(offs(a) / 4);
            for (int k = 0; k < 4; k++)
                if (b[k]) ref_mem[u][i][8*k +: 8] = d[8*k +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input int u, input logic [31:0] a);
        return in_rng(u, a) ? ref_mem[u][int'(offs(a) / 4)] : ERRD;
    endfunction

    // Drives one request and waits for its completion; l = cycles from
    // acceptance to busy low, -1 if the response never came.
    task automatic access(input int u, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output int l, output logic [31:0] rd, output logic e);
        bit done;
        @(posedge clk); #1;
        addr[u] = a; wdata[u] = d; be[u] = b; wen[u] = w; ren[u] = r;
        l = -1; rd = 'x; e = 1'bx; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (busy[u] === 1'b0) begin
                l = k; rd = rdata[u]; e = err[u]; done = 1'b1;
            end
        end
        @(posedge clk); #1;
        ren[u] = 1'b0; wen[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            n_cmp++; if (busy[u] !== 1'b1) begin n_fail++; $display("FAIL reset_busy u%0d got %b want 1", u, busy[u]); end
            n_cmp++; if (err[u] !== 1'b0) begin n_fail++; $display("FAIL reset_err u%0d got %b want 0", u, err[u]); end
            n_cmp++; if (rdata[u] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata u%0d got %h want 0", u, rdata[u]); end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL idle_busy got %b want 1", busy[0]); end
    endtask

    task automatic test_write_read();
        int l; logic [31:0] rd; logic e;
        access(0, 1, 0, BASE, 32'hDEAD_BEEF, 4'hF, l, rd, e);
        model_write(0, BASE, 32'hDEAD_BEEF, 4'hF);
        n_cmp++; if (l !== 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", l); end
        n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", e); end
        access(0, 0, 1, BASE, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (l !== 3) begin n_fail++; $display("FAIL rd_latency got %0d want 3", l); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", rd); end
        n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b want 0", e); end
    endtask

    task automatic test_byte_lanes();
        int l; logic [31:0] rd; logic e;
        access(0, 1, 0, BASE + 4, 32'h1122_3344, 4'hF, l, rd, e);
        access(0, 1, 0, BASE + 4, 32'hAABB_CCDD, 4'b0101, l, rd, e);
        access(0, 0, 1, BASE + 4, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_lanes got %h want 11bb33dd", rd); end
        access(0, 1, 0, BASE + 4, 32'hFFFF_FFFF, 4'h0, l, rd, e);
        n_cmp++; if (l !== 3 || e !== 1'b0) begin n_fail++; $display("FAIL be_zero_resp got lat %0d err %b want 3 0", l, e); end
        access(0, 0, 1, BASE + 4, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL be_zero_data got %h want 11bb33dd", rd); end
        model_write(0, BASE + 4, 32'h11BB_33DD, 4'hF);
    endtask

    task automatic test_range();
        int l; logic [31:0] rd; logic e;
        access(0, 0, 1, BASE - 4, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== ERRD || e !== 1'b1) begin n_fail++; $display("FAIL oor_low got %h/%b want bad1bad1/1", rd, e); end
        access(0, 0, 1, BASE + 4 * 4096, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== ERRD || e !== 1'b1) begin n_fail++; $display("FAIL oor_high got %h/%b want bad1bad1/1", rd, e); end
        access(0, 1, 0, BASE + 4 * 4095, 32'h0F0F_F0F0, 4'hF, l, rd, e);
        model_write(0, BASE + 4 * 4095, 32'h0F0F_F0F0, 4'hF);
        access(0, 1, 0, BASE + 4 * 4096, 32'h1234_5678, 4'hF, l, rd, e);
        n_cmp++; if (e !== 1'b1 || l !== 3) begin n_fail++; $display("FAIL oor_write got err %b lat %0d want 1 3", e, l); end
        access(0, 0, 1, BASE, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== ref_mem[0][0]) begin n_fail++; $display("FAIL oor_keep0 got %h want %h", rd, ref_mem[0][0]); end
        access(0, 0, 1, BASE + 4 * 4095, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== 32'h0F0F_F0F0 || e !== 1'b0) begin n_fail++; $display("FAIL oor_keep_last got %h/%b want 0f0ff0f0/0", rd, e); end
    endtask

    task automatic test_both();
        int l; logic [31:0] rd; logic e;
        access(0, 1, 1, BASE + 12, 32'hCAFE_F00D, 4'hF, l, rd, e);
        model_write(0, BASE + 12, 32'hCAFE_F00D, 4'hF);
        n_cmp++; if (rd !== 32'h0 || e !== 1'b0 || l !== 3) begin n_fail++; $display("FAIL both_resp got %h/%b/%0d want 0/0/3", rd, e, l); end
        access(0, 0, 1, BASE + 12, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL both_write got %h want cafef00d", rd); end
    endtask

    task automatic test_abort();
        int l; logic [31:0] rd; logic e;
        logic exp_b;
        access(1, 1, 0, BASE, 32'h0BB0_1234, 4'hF, l, rd, e);
        model_write(1, BASE, 32'h0BB0_1234, 4'hF);
        n_cmp++; if (l !== 4) begin n_fail++; $display("FAIL l3_latency got %0d want 4", l); end
        @(posedge clk); #1;
        addr[1] = BASE; ren[1] = 1'b1; wen[1] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            exp_b = (k != 7);
            n_cmp++; if (busy[1] !== exp_b) begin n_fail++; $display("FAIL abort_busy c%0d got %b want %b", k, busy[1], exp_b); end
            if (k == 7) begin
                n_cmp++; if (rdata[1] !== 32'h0BB0_1234) begin n_fail++; $display("FAIL abort_rdata got %h want 0bb01234", rdata[1]); end
            end
            @(posedge clk); #1;
            if (k + 1 == 1) ren[1] = 1'b0;
            if (k + 1 == 3) ren[1] = 1'b1;
            if (k + 1 == 8) ren[1] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int l; logic [31:0] rd; logic e;
        logic exp_b;
        for (int i = 0; i < 4; i++) begin
            access(2, 1, 0, BASE + 4 * i, 32'h2000_0000 + i, 4'hF, l, rd, e);
            model_write(2, BASE + 4 * i, 32'h2000_0000 + i, 4'hF);
        end
        n_cmp++; if (l !== 1) begin n_fail++; $display("FAIL l0_latency got %0d want 1", l); end
        @(posedge clk); #1;
        addr[2] = BASE; ren[2] = 1'b1; wen[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_b = (k % 2 == 0);
            n_cmp++; if (busy[2] !== exp_b) begin n_fail++; $display("FAIL b2b_busy c%0d got %b want %b", k, busy[2], exp_b); end
            if (k % 2 == 1) begin
                n_cmp++; if (rdata[2] !== ref_mem[2][k/2]) begin n_fail++; $display("FAIL b2b_rdata c%0d got %h want %h", k, rdata[2], ref_mem[2][k/2]); end
            end
            @(posedge clk); #1;
            if (k % 2 == 1) addr[2] = BASE + 4 * ((k + 1) / 2);
        end
        ren[2] = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset_resp();
        int l; logic [31:0] rd; logic e;
        bit found;
        access(0, 1, 0, BASE + 8, 32'h7777_0000, 4'hF, l, rd, e);
        model_write(0, BASE + 8, 32'h7777_0000, 4'hF);
        @(posedge clk); #1;
        addr[0] = BASE + 8; wdata[0] = 32'h5555_5555; be[0] = 4'hF; wen[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (busy[0] === 1'b0) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rst_resp_reach got none want busy low"); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy[0] !== 1'b1 || err[0] !== 1'b0) begin n_fail++; $display("FAIL rst_async got busy %b err %b want 1 0", busy[0], err[0]); end
        @(posedge clk); #2;
        wen[0] = 1'b0;
        rst = 1'b0;
        access(0, 0, 1, BASE + 8, 32'h0, 4'h0, l, rd, e);
        n_cmp++; if (rd !== 32'h7777_0000 || l !== 3) begin n_fail++; $display("FAIL rst_no_commit got %h lat %0d want 77770000 3", rd, l); end
    endtask

    task automatic test_random();
        int l; logic [31:0] rd; logic e;
        logic [31:0] a, d;
        logic [3:0] b;
        int kind;
        bit w, r;
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 8; i++) begin
                d = $urandom;
                access(u, 1, 0, BASE + 4 * i, d, 4'hF, l, rd, e);
                model_write(u, BASE + 4 * i, d, 4'hF);
            end
            for (int n = 0; n < 25; n++) begin
                kind = $urandom_range(0, 9);
                d = $urandom;
                b = 4'($urandom_range(0, 15));
                a = BASE + 4 * $urandom_range(0, 7);
                if (kind == 0 || kind == 1) begin
                    if ($urandom_range(0, 1) == 0) a = BASE - 4 * $urandom_range(1, 4);
                    else a = BASE + 4 * dep(u) + 4 * $urandom_range(0, 3);
                end
                w = (kind == 1 || kind == 2 || kind == 3 || kind == 4 || kind == 5);
                r = !w || (kind == 2);
                access(u, w, r, a, d, b, l, rd, e);
                n_cmp++; if (l !== 1 + lat(u)) begin n_fail++; $display("FAIL rnd_lat u%0d got %0d want %0d", u, l, 1 + lat(u)); end
                n_cmp++; if (e !== !in_rng(u, a)) begin n_fail++; $display("FAIL rnd_err u%0d a %h got %b want %b", u, a, e, !in_rng(u, a)); end
                if (r) begin
                    n_cmp++;
                    if (rd !== (w ? 32'h0 : model_read(u, a))) begin
                        n_fail++; $display("FAIL rnd_rdata u%0d a %h got %h want %h", u, a, rd, w ? 32'h0 : model_read(u, a));
                    end
                end
                if (w) model_write(u, a, d, b);
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            addr[u] = '0; wdata[u] = '0; ren[u] = 1'b0; wen[u] = 1'b0; be[u] = '0;
        end
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_range();
        test_both();
        test_abort();
        test_back_to_back();
        test_reset_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
